// File: rtl/regfile_mp_bypass.sv
// Multi-port register file with a multi-stage forwarding network and a long-op scoreboard.
// Optional committed-state debug read port when RF_DEBUG_PORT_EN is defined.
module regfile_mp_bypass #(
    parameter int DATA_W     = 32,
    parameter int NREG       = 32,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int BYP_STAGES = 2,
    localparam int AW        = $clog2(NREG)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    input  logic [NUM_RD*DATA_W-1:0]     rd_imm,
    output logic [NUM_RD*DATA_W-1:0]     rd_data,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*AW-1:0]         wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]     wr_data,
    input  logic [NUM_WR-1:0]            wr_lop,
    input  logic [BYP_STAGES-1:0]        byp_valid,
    input  logic [BYP_STAGES-1:0]        byp_ready,
    input  logic [BYP_STAGES*AW-1:0]     byp_addr,
    input  logic [BYP_STAGES*DATA_W-1:0] byp_data,
    input  logic                         sb_set,
    input  logic [AW-1:0]                sb_addr,
    input  logic                         sb_flush,
    output logic                         stall_req,
    output logic [NREG-1:0]              sb_busy,
    output logic [AW:0]                  sb_cnt
`ifdef RF_DEBUG_PORT_EN
    ,
    input  logic [AW-1:0]                dbg_addr,
    output logic [DATA_W-1:0]            dbg_data
`endif
);

    logic [DATA_W-1:0] regs [NREG];

    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic            sb_clr;
    logic            sb_hit;

    logic [AW-1:0]     rp_addr;
    logic [DATA_W-1:0] rp_data;
    logic              rp_stall;
    logic              rp_byp_hit;
    logic              rp_wr_hit;

    // Architectural array update; later write ports override earlier ones, r0 stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Next scoreboard state: a new issue beats both a completion and a flush
    always_comb begin
        busy_nxt = '0;
        cnt_nxt  = '0;
        sb_clr   = 1'b0;
        sb_hit   = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            sb_clr = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_lop[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
                    sb_clr = 1'b1;
                end
            end
            sb_hit = sb_set && (sb_addr == AW'(r)) && (r != 0);
            if (sb_flush) begin
                busy_nxt[r] = sb_hit;
            end else begin
                busy_nxt[r] = sb_hit | (sb_busy[r] & ~sb_clr);
            end
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
        end
    end

    // Scoreboard bits and their population count registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_busy <= '0;
            sb_cnt  <= '0;
        end else begin
            sb_busy <= busy_nxt;
            sb_cnt  <= cnt_nxt;
        end
    end

    // Operand select per port: imm, r0, youngest bypass stage, write port, scoreboard, array
    always_comb begin
        rd_data    = '0;
        stall_req  = 1'b0;
        rp_addr    = '0;
        rp_data    = '0;
        rp_stall   = 1'b0;
        rp_byp_hit = 1'b0;
        rp_wr_hit  = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            rp_addr    = rd_addr[i*AW +: AW];
            rp_data    = '0;
            rp_stall   = 1'b0;
            rp_byp_hit = 1'b0;
            rp_wr_hit  = 1'b0;
            if (!rd_en[i]) begin
                rp_data = rd_imm[i*DATA_W +: DATA_W];
            end else if (!rst && (rp_addr != '0)) begin
                for (int k = 0; k < BYP_STAGES; k++) begin
                    if (!rp_byp_hit && byp_valid[k] &&
                        (byp_addr[k*AW +: AW] == rp_addr)) begin
                        rp_byp_hit = 1'b1;
                        if (byp_ready[k]) begin
                            rp_data = byp_data[k*DATA_W +: DATA_W];
                        end else begin
                            rp_stall = 1'b1;
                        end
                    end
                end
                if (!rp_byp_hit) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (wr_en[j] && (wr_addr[j*AW +: AW] == rp_addr)) begin
                            rp_wr_hit = 1'b1;
                            rp_data   = wr_data[j*DATA_W +: DATA_W];
                        end
                    end
                    if (!rp_wr_hit) begin
                        if (sb_busy[rp_addr]) begin
                            rp_stall = 1'b1;
                        end else begin
                            rp_data = regs[rp_addr];
                        end
                    end
                end
            end
            rd_data[i*DATA_W +: DATA_W] = rp_data;
            stall_req = stall_req | rp_stall;
        end
    end

`ifdef RF_DEBUG_PORT_EN
    // Committed state only; r0 is held at zero in the array
    assign dbg_data = regs[dbg_addr];
`else
`endif

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Self-checking bench for regfile_mp_bypass.
// Directed scenarios plus randomized traffic against a reference model.
module tb_regfile_mp_bypass;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rd_en;
    logic [19:0]  rd_addr;
    logic [127:0] rd_imm;
    logic [127:0] rd_data;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [1:0]   wr_lop;
    logic [1:0]   byp_valid;
    logic [1:0]   byp_ready;
    logic [9:0]   byp_addr;
    logic [63:0]  byp_data;
    logic         sb_set;
    logic [4:0]   sb_addr;
    logic         sb_flush;
    logic         stall_req;
    logic [31:0]  sb_busy;
    logic [5:0]   sb_cnt;

    int checks = 0;
    int failures = 0;

    logic [31:0] mregs [32];
    logic [31:0] mbusy;

    regfile_mp_bypass dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_imm(rd_imm), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lop(wr_lop),
        .byp_valid(byp_valid), .byp_ready(byp_ready),
        .byp_addr(byp_addr), .byp_data(byp_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush),
        .stall_req(stall_req), .sb_busy(sb_busy), .sb_cnt(sb_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        rd_en = '0; rd_addr = '0; rd_imm = '0;
        wr_en = '0; wr_addr = '0; wr_data = '0; wr_lop = '0;
        byp_valid = '0; byp_ready = '0; byp_addr = '0; byp_data = '0;
        sb_set = 0; sb_addr = '0; sb_flush = 0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mregs[r] = '0;
        mbusy = '0;
    endtask

    // Apply one clock edge of architectural effects to the model
    task automatic model_edge();
        logic [31:0] clr, setv;
        if (rst) begin
            model_reset();
            return;
        end
        clr = '0;
        setv = '0;
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_lop[j]) clr[wr_addr[j*5 +: 5]] = 1'b1;
        if (sb_set && sb_addr != 0) setv[sb_addr] = 1'b1;
        mbusy = sb_flush ? setv : (setv | (mbusy & ~clr));
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_addr[j*5 +: 5] != 0)
                mregs[wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic void exp_rd(input int i, output logic [31:0] d, output bit st);
        logic [4:0] a;
        int wj;
        a = rd_addr[i*5 +: 5];
        d = '0;
        st = 0;
        if (!rd_en[i]) begin
            d = rd_imm[i*32 +: 32];
            return;
        end
        if (rst || a == 0) return;
        for (int k = 0; k < 2; k++) begin
            if (byp_valid[k] && byp_addr[k*5 +: 5] == a) begin
                if (byp_ready[k]) d = byp_data[k*32 +: 32];
                else st = 1;
                return;
            end
        end
        wj = -1;
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_addr[j*5 +: 5] == a) wj = j;
        if (wj >= 0) d = wr_data[wj*32 +: 32];
        else if (mbusy[a]) st = 1;
        else d = mregs[a];
    endfunction

    task automatic test_reset();
        clear_inputs();
        wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'h1234;
        sb_set = 1; sb_addr = 5'd3;
        tick();
        clear_inputs();
        rd_en = 4'b0001; rd_addr[4:0] = 5'd5;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h1234) begin
            failures++;
            $display("FAIL pre_reset_r5 got=%h exp=%h", rd_data[31:0], 32'h1234);
        end
        #2;
        rst = 1;
        model_reset();
        rd_en = 4'b0111;
        rd_addr = {5'd0, 5'd5, 5'd3, 5'd5};
        rd_imm[127:96] = 32'hDEAD_BEEF;
        byp_valid = 2'b01; byp_ready = 2'b01;
        byp_addr[4:0] = 5'd5; byp_data[31:0] = 32'h9999;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data[i*32 +: 32] !== 32'h0) begin
                failures++;
                $display("FAIL reset_rd%0d got=%h exp=0", i, rd_data[i*32 +: 32]);
            end
        end
        checks++;
        if (rd_data[127:96] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL reset_imm got=%h exp=deadbeef", rd_data[127:96]);
        end
        checks++;
        if (sb_cnt !== 6'd0 || sb_busy !== 32'h0) begin
            failures++;
            $display("FAIL reset_sb cnt=%0d busy=%h exp=0", sb_cnt, sb_busy);
        end
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b exp=0", stall_req);
        end
        tick();
        clear_inputs();
        #3;
        rst = 0;
        rd_en = 4'b0001; rd_addr[4:0] = 5'd5;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_r5 got=%h exp=0", rd_data[31:0]);
        end
        tick();
    endtask

    task automatic test_bypass_priority();
        clear_inputs();
        rd_en = 4'b0001; rd_addr[4:0] = 5'd3;
        byp_valid = 2'b11; byp_ready = 2'b11;
        byp_addr = {5'd3, 5'd3};
        byp_data = {32'hBBBB, 32'hAAAA};
        wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'hCCCC;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hAAAA) begin
            failures++;
            $display("FAIL byp_e got=%h exp=aaaa", rd_data[31:0]);
        end
        byp_valid = 2'b10;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hBBBB) begin
            failures++;
            $display("FAIL byp_m got=%h exp=bbbb", rd_data[31:0]);
        end
        byp_valid = 2'b00;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hCCCC) begin
            failures++;
            $display("FAIL byp_wr got=%h exp=cccc", rd_data[31:0]);
        end
        byp_valid = 2'b11; byp_ready = 2'b10;
        #1;
        checks++;
        if (stall_req !== 1'b1 || rd_data[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL byp_e_notready stall=%b data=%h exp=1/0", stall_req, rd_data[31:0]);
        end
        byp_valid = 2'b00;
        tick();
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        rd_en = 4'b0100; rd_addr[14:10] = 5'd7;
        byp_valid = 2'b01; byp_ready = 2'b00; byp_addr[4:0] = 5'd7;
        #1;
        checks++;
        if (stall_req !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall got=%b exp=1", stall_req);
        end
        byp_ready = 2'b01; byp_data[31:0] = 32'h55;
        #1;
        checks++;
        if (stall_req !== 1'b0 || rd_data[95:64] !== 32'h55) begin
            failures++;
            $display("FAIL load_ready stall=%b data=%h exp=0/55", stall_req, rd_data[95:64]);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_write_collision();
        clear_inputs();
        wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h22, 32'h11};
        tick();
        clear_inputs();
        rd_en = 4'b1000; rd_addr[19:15] = 5'd9;
        #1;
        checks++;
        if (rd_data[127:96] !== 32'h22) begin
            failures++;
            $display("FAIL collision_r9 got=%h exp=22", rd_data[127:96]);
        end
        wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'hFF;
        tick();
        clear_inputs();
        rd_en = 4'b0001; rd_addr[4:0] = 5'd0;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL r0_write got=%h exp=0", rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        clear_inputs();
        sb_set = 1; sb_addr = 5'd12;
        tick();
        clear_inputs();
        rd_en = 4'b0001; rd_addr[4:0] = 5'd12;
        #1;
        checks++;
        if (sb_cnt !== 6'd1 || sb_busy !== 32'h0000_1000) begin
            failures++;
            $display("FAIL sb_set cnt=%0d busy=%h exp=1/00001000", sb_cnt, sb_busy);
        end
        checks++;
        if (stall_req !== 1'b1) begin
            failures++;
            $display("FAIL sb_stall got=%b exp=1", stall_req);
        end
        wr_en = 2'b10; wr_lop = 2'b10; wr_addr[9:5] = 5'd12; wr_data[63:32] = 32'h77;
        #1;
        checks++;
        if (stall_req !== 1'b0 || rd_data[31:0] !== 32'h77) begin
            failures++;
            $display("FAIL sb_wb_bypass stall=%b data=%h exp=0/77", stall_req, rd_data[31:0]);
        end
        tick();
        clear_inputs();
        checks++;
        if (sb_cnt !== 6'd0 || sb_busy !== 32'h0) begin
            failures++;
            $display("FAIL sb_clear cnt=%0d busy=%h exp=0", sb_cnt, sb_busy);
        end
        sb_set = 1; sb_addr = 5'd12;
        tick();
        wr_en = 2'b01; wr_lop = 2'b01; wr_addr[4:0] = 5'd12; wr_data[31:0] = 32'h88;
        tick();
        clear_inputs();
        checks++;
        if (sb_cnt !== 6'd1 || sb_busy[12] !== 1'b1) begin
            failures++;
            $display("FAIL sb_set_beats_clr cnt=%0d busy12=%b exp=1/1", sb_cnt, sb_busy[12]);
        end
        wr_en = 2'b01; wr_lop = 2'b01; wr_addr[4:0] = 5'd12; wr_data[31:0] = 32'h99;
        tick();
        wr_en = 2'b01; wr_lop = 2'b01; wr_addr[4:0] = 5'd12;
        sb_set = 1; sb_addr = 5'd0;
        tick();
        clear_inputs();
        checks++;
        if (sb_cnt !== 6'd0 || sb_busy !== 32'h0) begin
            failures++;
            $display("FAIL sb_idle_clr_r0_set cnt=%0d busy=%h exp=0", sb_cnt, sb_busy);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        sb_set = 1; sb_addr = 5'd4;
        tick();
        sb_addr = 5'd6;
        tick();
        sb_addr = 5'd6;
        tick();
        checks++;
        if (sb_cnt !== 6'd2) begin
            failures++;
            $display("FAIL flush_pre cnt=%0d exp=2", sb_cnt);
        end
        sb_addr = 5'd8; sb_flush = 1;
        tick();
        clear_inputs();
        checks++;
        if (sb_busy !== 32'h0000_0100 || sb_cnt !== 6'd1) begin
            failures++;
            $display("FAIL flush busy=%h cnt=%0d exp=00000100/1", sb_busy, sb_cnt);
        end
        sb_flush = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [31:0] ed;
        bit est, any;
        for (int n = 0; n < 400; n++) begin
            rd_en = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                rd_addr[i*5 +: 5] = 5'($urandom_range(0, 9));
                rd_imm[i*32 +: 32] = $urandom;
            end
            wr_en = 2'($urandom);
            wr_lop = 2'($urandom);
            for (int j = 0; j < 2; j++) begin
                wr_addr[j*5 +: 5] = 5'($urandom_range(0, 9));
                wr_data[j*32 +: 32] = $urandom;
            end
            byp_valid = 2'($urandom);
            byp_ready = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                byp_addr[k*5 +: 5] = 5'($urandom_range(0, 9));
                byp_data[k*32 +: 32] = $urandom;
            end
            sb_set = ($urandom_range(0, 2) == 0);
            sb_addr = 5'($urandom_range(0, 9));
            sb_flush = ($urandom_range(0, 30) == 0);
            #1;
            any = 0;
            for (int i = 0; i < 4; i++) begin
                exp_rd(i, ed, est);
                any = any | est;
                checks++;
                if (rd_data[i*32 +: 32] !== ed) begin
                    failures++;
                    $display("FAIL rand_rd%0d n=%0d got=%h exp=%h", i, n, rd_data[i*32 +: 32], ed);
                end
            end
            checks++;
            if (stall_req !== any) begin
                failures++;
                $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall_req, any);
            end
            tick();
            checks++;
            if (sb_busy !== mbusy || sb_cnt !== 6'($countones(mbusy))) begin
                failures++;
                $display("FAIL rand_sb n=%0d busy=%h cnt=%0d exp=%h/%0d",
                         n, sb_busy, sb_cnt, mbusy, $countones(mbusy));
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        test_reset();
        test_bypass_priority();
        test_load_use();
        test_write_collision();
        test_scoreboard();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
